// File: rtl/liteic_pkg.sv
// Shared liteic crossbar constants, read-arbiter state type and index-width helper.
package liteic_pkg;

  localparam int unsigned IC_NUM_MASTER_SLOTS = 4;
  localparam int unsigned IC_ARADDR_WIDTH     = 20;
  localparam int unsigned IC_RDATA_WIDTH      = 34;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_AR,
    ARB_R
  } liteic_rd_arb_state_t;

  // Width of a binary index into n lanes; never less than one bit.
  function automatic int unsigned liteic_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/liteic_priority_cd_m.sv
// One-hot (or lowest-set-bit) to binary index encoder.
module liteic_priority_cd_m #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned OUT_W = 2
) (
  input  logic [WIDTH-1:0] i_onehot,
  output logic [OUT_W-1:0] o_idx
);

  always_comb begin
    o_idx = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (i_onehot[i]) begin
        o_idx = OUT_W'(i);
      end
    end
  end

endmodule

// File: rtl/liteic_rr_arbiter.sv
// Combinational round-robin arbiter: scans upward from the lane after i_last_grant, with wrap.
module liteic_rr_arbiter
  import liteic_pkg::*;
#(
  parameter int unsigned NUM_MST = 4,
  parameter int unsigned IDX_W   = liteic_idx_w(NUM_MST)
) (
  input  logic [NUM_MST-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last_grant,
  output logic [NUM_MST-1:0] o_grant_oh,
  output logic [IDX_W-1:0]   o_grant_idx
);

  logic [NUM_MST-1:0] w_grant_oh;
  logic [IDX_W-1:0]   w_idx;
  logic               w_found;

  always_comb begin
    w_grant_oh = '0;
    w_found    = 1'b0;
    w_idx      = '0;
    for (int unsigned off = 1; off <= NUM_MST; off++) begin
      w_idx = IDX_W'((32'(i_last_grant) + off) % NUM_MST);
      if (!w_found && i_req[w_idx]) begin
        w_grant_oh[w_idx] = 1'b1;
        w_found           = 1'b1;
      end
    end
  end

  assign o_grant_oh = w_grant_oh;

  liteic_priority_cd_m #(
    .WIDTH (NUM_MST),
    .OUT_W (IDX_W)
  ) u_cd (
    .i_onehot (w_grant_oh),
    .o_idx    (o_grant_idx)
  );

endmodule

// File: rtl/liteic_slave_node_read_arb.sv
// Slave-side read node: round-robin shares one AXI-Lite read slave among NUM_MST masters.
// Define LITEIC_RD_ARB_RSP_REG_EN to register the R path (1-entry buffer, +1 cycle latency).
module liteic_slave_node_read_arb
  import liteic_pkg::*;
#(
  parameter int unsigned NUM_MST = IC_NUM_MASTER_SLOTS,
  parameter int unsigned ADDR_W  = IC_ARADDR_WIDTH - 12,
  parameter int unsigned RDATA_W = IC_RDATA_WIDTH
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [NUM_MST-1:0] cbar_reqst_val_i,
  output logic [NUM_MST-1:0] cbar_reqst_rdy_o,
  input  logic [ADDR_W-1:0]  cbar_reqst_data_i [NUM_MST],
  output logic [NUM_MST-1:0] cbar_resp_val_o,
  input  logic [NUM_MST-1:0] cbar_resp_rdy_i,
  output logic [RDATA_W-1:0] cbar_resp_data_o,
  output logic               slv_ar_valid_o,
  input  logic               slv_ar_ready_i,
  output logic [ADDR_W-1:0]  slv_ar_addr_o,
  input  logic               slv_r_valid_i,
  output logic               slv_r_ready_o,
  input  logic [RDATA_W-1:0] slv_r_data_i
);

  localparam int unsigned IDX_W = liteic_idx_w(NUM_MST);

  liteic_rd_arb_state_t r_state, w_state_nxt;
  logic [IDX_W-1:0]     r_grant, r_last_grant;
  logic [ADDR_W-1:0]    r_addr;
  logic [NUM_MST-1:0]   w_grant_oh;
  logic [IDX_W-1:0]     w_grant_idx;
  logic                 w_req_hs;

`ifdef LITEIC_RD_ARB_RSP_REG_EN
  logic               r_rsp_full;
  logic [RDATA_W-1:0] r_rsp_data;
  logic               w_rsp_cap;
  logic               w_rsp_pop;
`endif

  liteic_rr_arbiter #(
    .NUM_MST (NUM_MST),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req        (cbar_reqst_val_i),
    .i_last_grant (r_last_grant),
    .o_grant_oh   (w_grant_oh),
    .o_grant_idx  (w_grant_idx)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_req_hs         = 1'b0;
    cbar_reqst_rdy_o = '0;
    cbar_resp_val_o  = '0;
    cbar_resp_data_o = '0;
    slv_ar_valid_o   = 1'b0;
    slv_r_ready_o    = 1'b0;
`ifdef LITEIC_RD_ARB_RSP_REG_EN
    w_rsp_cap        = 1'b0;
    w_rsp_pop        = 1'b0;
`endif
    unique case (r_state)
      ARB_IDLE: begin
        // Gated by reset so the ready lines read zero while reset is held.
        cbar_reqst_rdy_o = w_grant_oh & {NUM_MST{rstn_i}};
        w_req_hs         = |w_grant_oh;
        if (w_req_hs) begin
          w_state_nxt = ARB_AR;
        end
      end
      ARB_AR: begin
        slv_ar_valid_o = 1'b1;
        if (slv_ar_ready_i) begin
          w_state_nxt = ARB_R;
        end
      end
      ARB_R: begin
`ifdef LITEIC_RD_ARB_RSP_REG_EN
        slv_r_ready_o            = ~r_rsp_full;
        w_rsp_cap                = slv_r_valid_i & ~r_rsp_full;
        cbar_resp_val_o[r_grant] = r_rsp_full;
        cbar_resp_data_o         = r_rsp_data;
        w_rsp_pop                = r_rsp_full & cbar_resp_rdy_i[r_grant];
        if (w_rsp_pop) begin
          w_state_nxt = ARB_IDLE;
        end
`else
        cbar_resp_val_o[r_grant] = slv_r_valid_i;
        cbar_resp_data_o         = slv_r_data_i;
        slv_r_ready_o            = cbar_resp_rdy_i[r_grant];
        if (slv_r_valid_i && cbar_resp_rdy_i[r_grant]) begin
          w_state_nxt = ARB_IDLE;
        end
`endif
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= ARB_IDLE;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(NUM_MST - 1);
      r_addr       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_hs) begin
        r_grant      <= w_grant_idx;
        r_last_grant <= w_grant_idx;
        r_addr       <= cbar_reqst_data_i[w_grant_idx];
      end
    end
  end

`ifdef LITEIC_RD_ARB_RSP_REG_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rsp_full <= 1'b0;
      r_rsp_data <= '0;
    end else if (w_rsp_cap) begin
      r_rsp_full <= 1'b1;
      r_rsp_data <= slv_r_data_i;
    end else if (w_rsp_pop) begin
      r_rsp_full <= 1'b0;
    end
  end
`endif

  assign slv_ar_addr_o = r_addr;

endmodule

// File: tb/tb_liteic_slave_node_read_arb.sv
// Self-checking bench for liteic_slave_node_read_arb: directed cases plus randomized transactions.
module tb_liteic_slave_node_read_arb;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int RW = 34;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  cbar_reqst_val_i;
  logic [N-1:0]  cbar_reqst_rdy_o;
  logic [AW-1:0] cbar_reqst_data_i [N];
  logic [N-1:0]  cbar_resp_val_o;
  logic [N-1:0]  cbar_resp_rdy_i;
  logic [RW-1:0] cbar_resp_data_o;
  logic          slv_ar_valid_o;
  logic          slv_ar_ready_i;
  logic [AW-1:0] slv_ar_addr_o;
  logic          slv_r_valid_i;
  logic          slv_r_ready_o;
  logic [RW-1:0] slv_r_data_i;

  int            n_pass  = 0;
  int            n_total = 0;
  int            m_last;
  logic [AW-1:0] addr [N];

  always #5 clk = ~clk;

  liteic_slave_node_read_arb #(
    .NUM_MST (N),
    .ADDR_W  (AW),
    .RDATA_W (RW)
  ) dut (
    .clk_i             (clk),
    .rstn_i            (rstn),
    .cbar_reqst_val_i  (cbar_reqst_val_i),
    .cbar_reqst_rdy_o  (cbar_reqst_rdy_o),
    .cbar_reqst_data_i (cbar_reqst_data_i),
    .cbar_resp_val_o   (cbar_resp_val_o),
    .cbar_resp_rdy_i   (cbar_resp_rdy_i),
    .cbar_resp_data_o  (cbar_resp_data_o),
    .slv_ar_valid_o    (slv_ar_valid_o),
    .slv_ar_ready_i    (slv_ar_ready_i),
    .slv_ar_addr_o     (slv_ar_addr_o),
    .slv_r_valid_i     (slv_r_valid_i),
    .slv_r_ready_o     (slv_r_ready_o),
    .slv_r_data_i      (slv_r_data_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference rule: first requester after the last served master, wrapping.
  function automatic int rr_pick(input int last, input logic [N-1:0] mask);
    for (int off = 1; off <= N; off++) begin
      int idx;
      idx = (last + off) % N;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_reqst_rdy"}, cbar_reqst_rdy_o, 0);
    check({tag, "_resp_val"}, cbar_resp_val_o, 0);
    check({tag, "_resp_data"}, cbar_resp_data_o, 0);
    check({tag, "_ar_valid"}, slv_ar_valid_o, 0);
    check({tag, "_ar_addr"}, slv_ar_addr_o, 0);
    check({tag, "_r_ready"}, slv_r_ready_o, 0);
  endtask

  // One full read: grant in IDLE, AR with stalls, R with slave delay and master back-pressure.
  // Entered and left at posedge+1 with the DUT in IDLE.
  task automatic do_txn(input logic [N-1:0] mask, input logic [N-1:0] pend, input int ar_stall,
                        input int r_delay, input int m_stall, input logic [RW-1:0] rdata);
    logic [N-1:0] oh;
    int           g;
    for (int i = 0; i < N; i++) cbar_reqst_data_i[i] = addr[i];
    cbar_reqst_val_i = mask;
    g  = rr_pick(m_last, mask);
    oh = '0;
    if (g >= 0) oh[g] = 1'b1;
    @(negedge clk);
    check("idle_ar_valid", slv_ar_valid_o, 0);
    check("idle_resp_val", cbar_resp_val_o, 0);
    check("idle_resp_data", cbar_resp_data_o, 0);
    check("grant", cbar_reqst_rdy_o, oh);
    if (g < 0) begin
      step();
      cbar_reqst_val_i = '0;
      return;
    end
    m_last = g;
    step();
    cbar_reqst_val_i = pend;
    for (int s = 0; s <= ar_stall; s++) begin
      slv_ar_ready_i = (s == ar_stall);
      @(negedge clk);
      check("ar_valid", slv_ar_valid_o, 1);
      check("ar_addr", slv_ar_addr_o, addr[g]);
      check("ar_rdy_blocked", cbar_reqst_rdy_o, 0);
      step();
    end
    slv_ar_ready_i = 1'b0;
    for (int d = 0; d < r_delay; d++) begin
      @(negedge clk);
      check("r_wait_val", cbar_resp_val_o, 0);
      check("r_wait_ar_valid", slv_ar_valid_o, 0);
      check("r_wait_rdy_blocked", cbar_reqst_rdy_o, 0);
      step();
    end
    slv_r_valid_i = 1'b1;
    slv_r_data_i  = rdata;
`ifdef LITEIC_RD_ARB_RSP_REG_EN
    cbar_resp_rdy_i = '0;
    @(negedge clk);
    check("reg_capture_rdy", slv_r_ready_o, 1);
    check("reg_val_early", cbar_resp_val_o, 0);
    step();
    slv_r_valid_i = 1'b0;
    for (int s = 0; s <= m_stall; s++) begin
      cbar_resp_rdy_i = (~oh & N'($urandom)) | ((s == m_stall) ? oh : '0);
      @(negedge clk);
      check("reg_resp_val", cbar_resp_val_o, oh);
      check("reg_resp_data", cbar_resp_data_o, rdata);
      check("reg_full_rdy", slv_r_ready_o, 0);
      step();
    end
`else
    for (int s = 0; s <= m_stall; s++) begin
      cbar_resp_rdy_i = (~oh & N'($urandom)) | ((s == m_stall) ? oh : '0);
      @(negedge clk);
      check("resp_val", cbar_resp_val_o, oh);
      check("resp_data", cbar_resp_data_o, rdata);
      check("r_ready", slv_r_ready_o, (s == m_stall));
      check("r_rdy_blocked", cbar_reqst_rdy_o, 0);
      step();
    end
`endif
    slv_r_valid_i    = 1'b0;
    cbar_resp_rdy_i  = '0;
    cbar_reqst_val_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn             = 1'b0;
    cbar_reqst_val_i = '1;
    cbar_resp_rdy_i  = '0;
    slv_ar_ready_i   = 1'b0;
    slv_r_valid_i    = 1'b0;
    slv_r_data_i     = '0;
    for (int i = 0; i < N; i++) begin
      cbar_reqst_data_i[i] = '0;
      addr[i]              = AW'($urandom);
    end
    #12;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rstn             = 1'b1;
    cbar_reqst_val_i = '0;
    m_last           = N - 1;

    // Single request from master 2, AR stalled 5 cycles, master stalls 3 cycles.
    addr[2] = 8'h3A;
    do_txn(4'b0100, 4'b1011, 5, 1, 3, {32'hDEADBEEF, 2'b00});

    // Reset asserted while in R.
    cbar_reqst_data_i[1] = 8'h55;
    cbar_reqst_val_i     = 4'b0010;
    @(negedge clk);
    check("mid_grant", cbar_reqst_rdy_o, 4'b0010);
    step();
    cbar_reqst_val_i = 4'hF;
    slv_ar_ready_i   = 1'b1;
    @(negedge clk);
    check("mid_ar_addr", slv_ar_addr_o, 8'h55);
    step();
    slv_ar_ready_i  = 1'b0;
    slv_r_valid_i   = 1'b1;
    slv_r_data_i    = 34'h1_2345_6789;
    cbar_resp_rdy_i = '0;
`ifdef LITEIC_RD_ARB_RSP_REG_EN
    step();
`endif
    @(negedge clk);
    check("mid_r_val", cbar_resp_val_o, 4'b0010);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("async_reset");
    step();
    step();
    slv_r_valid_i    = 1'b0;
    cbar_reqst_val_i = '0;
    rstn             = 1'b1;
    m_last           = N - 1;

    // All masters request continuously: service order 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N; i++) addr[i] = AW'($urandom);
      do_txn('1, '1, $urandom_range(0, 1), 0, 0, RW'({$urandom, $urandom}));
    end

    // Randomized traffic, including empty request cycles.
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < N; i++) addr[i] = AW'($urandom);
      do_txn(N'($urandom), N'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
             $urandom_range(0, 2), RW'({$urandom, $urandom}));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/liteic_slave_node_read_arb.md
Name: liteic_slave_node_read_arb

Overview:
Slave-side read node of the liteic crossbar. It shares one AXI-Lite read slave between NUM_MST master read nodes.
- Accepts one AR request at a time using round-robin arbitration.
- Forwards the address to the slave.
- Returns the R beat to the granted master only.
- Sits between the crossbar matrix (cbar_* ports, one lane per master) and the slave's AR/R channels.
- One outstanding transaction per slave.

Parameters:
NUM_MST, 4, number of master read nodes sharing this slave (≥1)
ADDR_W, 8, request address width forwarded by the master node (IC_ARADDR_WIDTH-12)
RDATA_W, 34, response word width: {r_data, r_resp}

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset, asynchronous, active-low
cbar_reqst_val_i  in  NUM_MST  per-master AR valid
cbar_reqst_rdy_o  out  NUM_MST  per-master AR ready, one-hot or zero
cbar_reqst_data_i  in  ADDR_W x NUM_MST (unpacked)  per-master address
cbar_resp_val_o  out  NUM_MST  per-master R valid, one-hot or zero
cbar_resp_rdy_i  in  NUM_MST  per-master R ready
cbar_resp_data_o  out  RDATA_W  R word, broadcast to all masters
slv_ar_valid_o  out  1  slave AR valid
slv_ar_ready_i  in  1  slave AR ready
slv_ar_addr_o  out  ADDR_W  slave AR address (registered)
slv_r_valid_i  in  1  slave R valid
slv_r_ready_o  out  1  slave R ready
slv_r_data_i  in  RDATA_W  slave R word {r_data, r_resp}

Behaviour:
- Clock and reset: one clock, clk_i. rstn_i is asynchronous and active-low. Reset puts the FSM in IDLE, grant_r=0 and last_grant_r=NUM_MST-1, so master 0 has first priority.
- Outputs in reset: all outputs 0 (slv_ar_addr_o=0).
- FSM states: IDLE, AR, R.
- IDLE:
  - Grant goes to the first asserted cbar_reqst_val_i, scanning from (last_grant_r+1) mod NUM_MST upward with wrap.
  - cbar_reqst_rdy_o[g]=1, combinationally, in the same cycle; all other ready bits are 0.
  - On that handshake: latch the address into slv_ar_addr_o, latch g into grant_r and last_grant_r, go to AR.
  - With no valid request, stay in IDLE and leave the pointer unchanged.
- AR:
  - slv_ar_valid_o=1, held until slv_ar_ready_i.
  - Address is stable while valid.
  - On ready, go to R. Request-to-AR-valid latency is 1 cycle.
- R:
  - cbar_resp_val_o[grant_r]=slv_r_valid_i and cbar_resp_data_o=slv_r_data_i (combinational pass-through).
  - slv_r_ready_o=cbar_resp_rdy_i[grant_r].
  - On handshake, go to IDLE. The next grant can happen in the following cycle at the earliest.
  - Non-granted ready bits are ignored.
  - cbar_resp_data_o is 0 outside R.
- cbar_reqst_rdy_o is 0 in AR and R. Requests arriving there wait; master nodes hold valid.
- Fairness: after master k is served, k has lowest priority. Any continuously requesting master is served within NUM_MST grants.
- Request dropped: a request deasserted before the grant cycle is simply not granted. No state is kept.
- Slave behaviour: slv_r_valid_i outside R is a slave protocol violation; slv_r_ready_o stays 0.
- Reset mid-transaction: the transaction is abandoned and the FSM returns to IDLE. The reset is system-wide, so no drain is performed.
- NUM_MST=1: the arbiter degenerates to a pass-through with the same FSM.

Optional Feature:
LITEIC_RD_ARB_RSP_REG_EN
- Defined: the R path gets a 1-entry output register.
  - In R, slv_r_ready_o=~rsp_full.
  - The slave beat is captured into the register, then presented on cbar_resp_val_o[grant_r]/cbar_resp_data_o from the register.
  - The FSM leaves R on the master handshake.
  - Latency: +1 cycle on response; cuts the combinational ready/valid path through the arbiter.
- Undefined: combinational pass-through as described above.

Decomposition:
- liteic_pkg gets: IC_NUM_MASTER_SLOTS (default source for NUM_MST), IC_ARADDR_WIDTH, IC_RDATA_WIDTH, and typedef enum logic [1:0] {ARB_IDLE, ARB_AR, ARB_R} liteic_rd_arb_state_t.
- Sub-module liteic_rr_arbiter (NUM_MST): inputs req vector and last-grant index; outputs one-hot grant and binary index. Purely combinational, reusable by the write-side arbiter.
- liteic_priority_cd_m is reused for one-hot to binary conversion.

Test Plan:
- Reset, then a single request from master 2 with addr 0x3A: rdy_o=4'b0100 that cycle. Next cycle slv_ar_valid_o=1 and addr=0x3A. Slave R {0xDEADBEEF,2'b00} appears on cbar_resp_val_o=4'b0100 only.
- All 4 masters request continuously with back-to-back responses: grant order is 0,1,2,3,0. Each grant is followed by exactly one AR and one R.
- Slave holds slv_ar_ready_i=0 for 5 cycles: valid and address stay stable. cbar_reqst_rdy_o=0 throughout, even with new requests pending.
- Granted master holds cbar_resp_rdy_i=0 for 3 cycles while the slave presents R: slv_r_ready_o=0 and data is held. A non-granted master asserting its ready has no effect.
- rstn_i asserted asynchronously during state R: all outputs go to 0 immediately. After release, the first grant goes to master 0.
- With LITEIC_RD_ARB_RSP_REG_EN: the R beat appears on cbar_resp_val_o one cycle after the slave handshake. slv_r_ready_o=0 while the register is full.
